// File: rtl/csr_trap_sequencer.sv
// Machine-mode CSR port controller: passes core Zicsr accesses through in IDLE and
// sequences the trap-entry and mret CSR updates, ending each with a PC redirect.
module csr_trap_sequencer #(
    parameter int unsigned       CSR_AW    = 12,
    parameter logic [CSR_AW-1:0] MSTATUS_A = 12'h300,
    parameter logic [CSR_AW-1:0] MTVEC_A   = 12'h305,
    parameter logic [CSR_AW-1:0] MEPC_A    = 12'h341,
    parameter logic [CSR_AW-1:0] MCAUSE_A  = 12'h342
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [31:0]       trap_pc,
    input  logic [31:0]       trap_cause,
    input  logic              mret_valid,
    output logic              mret_ready,
    input  logic              core_csr_we,
    input  logic [CSR_AW-1:0] core_csr_waddr,
    input  logic [31:0]       core_csr_wdata,
    input  logic [CSR_AW-1:0] core_csr_raddr,
    input  logic [31:0]       csr_out,
    output logic              csr_write,
    output logic [CSR_AW-1:0] csr_write_addr,
    output logic [31:0]       csr_data,
    output logic [CSR_AW-1:0] csr_read_addr,
    output logic              busy,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] T_EPC    = 3'd1;
    localparam logic [2:0] T_CAUSE  = 3'd2;
    localparam logic [2:0] T_STATUS = 3'd3;
    localparam logic [2:0] T_JUMP   = 3'd4;
    localparam logic [2:0] M_STATUS = 3'd5;
    localparam logic [2:0] M_EPC    = 3'd6;
    localparam logic [2:0] M_JUMP   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] status_q, status_d;
    logic [31:0] tvec_q, tvec_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        status_d       = status_q;
        tvec_d         = tvec_q;
        redirect_pc_d  = redirect_pc_q;
        trap_ready     = 1'b0;
        mret_ready     = 1'b0;
        csr_write      = 1'b0;
        csr_write_addr = '0;
        csr_data       = '0;
        csr_read_addr  = '0;
        redirect_valid = 1'b0;

        case (state_q)
            IDLE: begin
                csr_write      = core_csr_we;
                csr_write_addr = core_csr_waddr;
                csr_data       = core_csr_wdata;
                csr_read_addr  = core_csr_raddr;
                if (trap_valid) begin
                    trap_ready = 1'b1;
                    epc_d      = trap_pc;
                    cause_d    = trap_cause;
                    state_d    = T_EPC;
                end else if (mret_valid) begin
                    mret_ready = 1'b1;
                    state_d    = M_STATUS;
                end
            end
            T_EPC: begin
                csr_write      = 1'b1;
                csr_write_addr = MEPC_A;
                csr_data       = epc_q;
                csr_read_addr  = MSTATUS_A;
                status_d       = csr_out;
                state_d        = T_CAUSE;
            end
            T_CAUSE: begin
                // Direct mode only: mode bits are dropped as mtvec is captured.
                csr_write      = 1'b1;
                csr_write_addr = MCAUSE_A;
                csr_data       = cause_q;
                csr_read_addr  = MTVEC_A;
                tvec_d         = {csr_out[31:2], 2'b00};
                state_d        = T_STATUS;
            end
            T_STATUS: begin
                csr_write      = 1'b1;
                csr_write_addr = MSTATUS_A;
                csr_data       = status_q;
                csr_data[7]    = status_q[3];
                csr_data[3]    = 1'b0;
                csr_data[12:11] = 2'b11;
                redirect_pc_d  = tvec_q;
                state_d        = T_JUMP;
            end
            T_JUMP: begin
                redirect_valid = 1'b1;
                state_d        = IDLE;
            end
            M_STATUS: begin
                csr_read_addr  = MSTATUS_A;
                status_d       = csr_out;
                state_d        = M_EPC;
            end
            M_EPC: begin
                // redirect_pc is registered, so the mepc read loads it directly.
                csr_write      = 1'b1;
                csr_write_addr = MSTATUS_A;
                csr_data       = status_q;
                csr_data[3]    = status_q[7];
                csr_data[7]    = 1'b1;
                csr_data[12:11] = 2'b11;
                csr_read_addr  = MEPC_A;
                epc_d          = csr_out;
                redirect_pc_d  = csr_out;
                state_d        = M_JUMP;
            end
            M_JUMP: begin
                redirect_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            csr_write      = 1'b0;
            trap_ready     = 1'b0;
            mret_ready     = 1'b0;
            redirect_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            epc_q         <= '0;
            cause_q       <= '0;
            status_q      <= '0;
            tvec_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            status_q      <= status_d;
            tvec_q        <= tvec_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: a CSR file model on the DUT ports plus a
// spec-level model of CSR contents, expected write order and redirect targets.
module tb_csr_trap_sequencer;

    localparam logic [11:0] A_STATUS = 12'h300;
    localparam logic [11:0] A_TVEC   = 12'h305;
    localparam logic [11:0] A_EPC    = 12'h341;
    localparam logic [11:0] A_CAUSE  = 12'h342;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, trap_ready, mret_valid, mret_ready;
    logic [31:0] trap_pc, trap_cause;
    logic        core_csr_we;
    logic [11:0] core_csr_waddr, core_csr_raddr;
    logic [31:0] core_csr_wdata;
    logic [31:0] csr_out;
    logic        csr_write;
    logic [11:0] csr_write_addr, csr_read_addr;
    logic [31:0] csr_data;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    csr_trap_sequencer #(
        .CSR_AW(12), .MSTATUS_A(12'h300), .MTVEC_A(12'h305),
        .MEPC_A(12'h341), .MCAUSE_A(12'h342)
    ) dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mret_ready(mret_ready),
        .core_csr_we(core_csr_we), .core_csr_waddr(core_csr_waddr),
        .core_csr_wdata(core_csr_wdata), .core_csr_raddr(core_csr_raddr),
        .csr_out(csr_out), .csr_write(csr_write), .csr_write_addr(csr_write_addr),
        .csr_data(csr_data), .csr_read_addr(csr_read_addr), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR file the DUT drives; not reset, as a real CSR file would survive a sequencer reset.
    logic [31:0] f_status = '0, f_tvec = '0, f_epc = '0, f_cause = '0;
    logic [11:0] wa_log[$];
    logic [31:0] wd_log[$];
    int          nstrobe = 0;

    always_comb begin
        case (csr_read_addr)
            A_STATUS: csr_out = f_status;
            A_TVEC:   csr_out = f_tvec;
            A_EPC:    csr_out = f_epc;
            A_CAUSE:  csr_out = f_cause;
            default:  csr_out = '0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_write) begin
            case (csr_write_addr)
                A_STATUS: f_status <= csr_data;
                A_TVEC:   f_tvec   <= csr_data;
                A_EPC:    f_epc    <= csr_data;
                A_CAUSE:  f_cause  <= csr_data;
                default:  ;
            endcase
            wa_log.push_back(csr_write_addr);
            wd_log.push_back(csr_data);
        end
        if (redirect_valid) nstrobe <= nstrobe + 1;
    end

    // Reference model state: architectural CSR contents as the spec defines them.
    logic [31:0] m_status = '0, m_tvec = '0, m_epc = '0, m_cause = '0;
    int nerr = 0;
    int nchk = 0;

    function automatic logic [31:0] trap_status(input logic [31:0] s);
        return (s & ~32'h0000_1888) | 32'h0000_1800 | (s[3] ? 32'h0000_0080 : 32'h0);
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] s);
        return (s & ~32'h0000_1888) | 32'h0000_1880 | (s[7] ? 32'h0000_0008 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic [11:0] a, input logic [31:0] d);
        case (a)
            A_STATUS: m_status = d;
            A_TVEC:   m_tvec   = d;
            A_EPC:    m_epc    = d;
            A_CAUSE:  m_cause  = d;
            default:  ;
        endcase
    endtask

    task automatic chk_file();
        chk("file_mstatus", f_status, m_status);
        chk("file_mtvec",   f_tvec,   m_tvec);
        chk("file_mepc",    f_epc,    m_epc);
        chk("file_mcause",  f_cause,  m_cause);
    endtask

    task automatic chk_log(input int base, input int idx, input logic [11:0] a, input logic [31:0] d);
        if (base + idx < wa_log.size()) begin
            chk("wr_addr", {20'h0, wa_log[base+idx]}, {20'h0, a});
            chk("wr_data", wd_log[base+idx], d);
        end else begin
            chk("wr_missing", 32'(idx), 32'hFFFF_FFFF);
        end
    endtask

    task automatic core_wr(input logic [11:0] a, input logic [31:0] d, input logic [11:0] ra);
        core_csr_we = 1'b1; core_csr_waddr = a; core_csr_wdata = d; core_csr_raddr = ra;
        @(negedge clk);
        chk1("idle_we_pass", csr_write, 1'b1);
        chk("idle_waddr_pass", {20'h0, csr_write_addr}, {20'h0, a});
        chk("idle_wdata_pass", csr_data, d);
        chk("idle_raddr_pass", {20'h0, csr_read_addr}, {20'h0, ra});
        chk1("idle_busy", busy, 1'b0);
        tick();
        core_csr_we = 1'b0;
        model_wr(a, d);
        chk_file();
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic cw, input logic [11:0] cwa, input logic [31:0] cwd,
                           input logic inject, input logic mret_too);
        int base, s0;
        logic [31:0] exp_st, exp_pc;
        trap_valid = 1'b1; trap_pc = pc; trap_cause = cause; mret_valid = mret_too;
        core_csr_we = cw; core_csr_waddr = cwa; core_csr_wdata = cwd;
        @(negedge clk);
        chk1("trap_ready_acc", trap_ready, 1'b1);
        chk1("mret_ready_acc", mret_ready, 1'b0);
        chk1("busy_acc", busy, 1'b0);
        chk1("acc_core_we", csr_write, cw);
        if (cw) model_wr(cwa, cwd);
        tick();
        trap_valid = 1'b0; core_csr_we = 1'b0;
        base = wa_log.size(); s0 = nstrobe;
        exp_st = trap_status(m_status);
        exp_pc = m_tvec & 32'hFFFF_FFFC;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2 && inject) begin
                core_csr_we = 1'b1; core_csr_waddr = A_STATUS; core_csr_wdata = $urandom;
            end
            @(negedge clk);
            chk1("trap_busy", busy, 1'b1);
            chk1("trap_ready_seq", trap_ready, 1'b0);
            chk1("mret_ready_seq", mret_ready, 1'b0);
            chk1("trap_redir_v", redirect_valid, k == 4);
            if (k == 2) begin
                chk1("tcause_we", csr_write, 1'b1);
                chk("tcause_addr", {20'h0, csr_write_addr}, {20'h0, A_CAUSE});
                chk("tcause_data", csr_data, cause);
            end
            if (k == 4) chk("trap_redir_pc", redirect_pc, exp_pc);
            tick();
            core_csr_we = 1'b0;
        end
        chk("trap_nwrites", 32'(wa_log.size() - base), 32'd3);
        chk_log(base, 0, A_EPC, pc);
        chk_log(base, 1, A_CAUSE, cause);
        chk_log(base, 2, A_STATUS, exp_st);
        chk("trap_strobes", 32'(nstrobe - s0), 32'd1);
        m_epc = pc; m_cause = cause; m_status = exp_st;
        chk_file();
        @(negedge clk);
        chk1("post_trap_rv", redirect_valid, 1'b0);
        chk("post_trap_hold", redirect_pc, exp_pc);
        chk1("post_trap_mret_ready", mret_ready, mret_too);
        tick();
    endtask

    task automatic mret_body();
        int base, s0;
        logic [31:0] exp_st, exp_pc;
        mret_valid = 1'b0;
        base = wa_log.size(); s0 = nstrobe;
        exp_st = mret_status(m_status);
        exp_pc = m_epc;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk1("mret_busy", busy, 1'b1);
            chk1("mret_ready_seq", mret_ready, 1'b0);
            chk1("mret_redir_v", redirect_valid, k == 3);
            if (k == 3) chk("mret_redir_pc", redirect_pc, exp_pc);
            tick();
        end
        chk("mret_nwrites", 32'(wa_log.size() - base), 32'd1);
        chk_log(base, 0, A_STATUS, exp_st);
        chk("mret_strobes", 32'(nstrobe - s0), 32'd1);
        m_status = exp_st;
        chk_file();
        @(negedge clk);
        chk1("post_mret_rv", redirect_valid, 1'b0);
        chk("post_mret_hold", redirect_pc, exp_pc);
        tick();
    endtask

    task automatic do_mret();
        mret_valid = 1'b1;
        @(negedge clk);
        chk1("mret_ready_acc", mret_ready, 1'b1);
        chk1("trap_ready_macc", trap_ready, 1'b0);
        chk1("busy_macc", busy, 1'b0);
        tick();
        mret_body();
    endtask

    task automatic do_trap_reset(input logic [31:0] pc, input logic [31:0] cause);
        int base, s0;
        trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
        @(negedge clk);
        chk1("rtrap_ready", trap_ready, 1'b1);
        tick();
        trap_valid = 1'b0;
        base = wa_log.size(); s0 = nstrobe;
        tick();
        rst = 1'b1; core_csr_we = 1'b1; core_csr_waddr = A_STATUS; core_csr_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk1("rst_no_write", csr_write, 1'b0);
        chk1("rst_no_redir", redirect_valid, 1'b0);
        tick();
        rst = 1'b0; core_csr_we = 1'b0;
        @(negedge clk);
        chk1("after_rst_busy", busy, 1'b0);
        chk1("after_rst_rv", redirect_valid, 1'b0);
        chk("after_rst_pc", redirect_pc, 32'h0);
        tick();
        chk("rst_nwrites", 32'(wa_log.size() - base), 32'd1);
        chk("rst_strobes", 32'(nstrobe - s0), 32'd0);
        m_epc = pc;
        chk_file();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst = 1'b1; trap_valid = 1'b1; mret_valid = 1'b1;
        trap_pc = '0; trap_cause = '0;
        core_csr_we = 1'b1; core_csr_waddr = A_STATUS; core_csr_wdata = 32'hDEAD_BEEF;
        core_csr_raddr = A_STATUS;
        tick();
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rv", redirect_valid, 1'b0);
        chk("rst_pc", redirect_pc, 32'h0);
        chk1("rst_trap_ready", trap_ready, 1'b0);
        chk1("rst_mret_ready", mret_ready, 1'b0);
        chk1("rst_csr_write", csr_write, 1'b0);
        tick();
        trap_valid = 1'b0; mret_valid = 1'b0; core_csr_we = 1'b0;
        tick();
        rst = 1'b0;
        chk_file();

        core_wr(A_TVEC, 32'h8000_0100, A_TVEC);
        core_wr(A_STATUS, 32'h0000_0008, A_EPC);
        do_trap(32'h8000_0040, 32'd11, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("plan_status_trap", f_status, 32'h0000_1880);
        do_mret();
        chk("plan_status_mret", f_status, 32'h0000_1888);

        core_wr(A_TVEC, 32'h8000_0103, A_CAUSE);
        s0 = nstrobe;
        do_trap($urandom, $urandom_range(0, 15), 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        mret_body();
        chk("both_strobes", 32'(nstrobe - s0), 32'd2);

        do_trap(32'h8000_0200, 32'd2, 1'b0, A_STATUS, 32'h0, 1'b1, 1'b0);
        do_trap(32'h8000_0300, 32'd3, 1'b1, A_STATUS, $urandom, 1'b0, 1'b0);
        do_trap_reset(32'h8000_0400, 32'd5);
        do_mret();

        for (int i = 0; i < 40; i++) begin
            int op;
            logic [11:0] a;
            op = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0: a = A_STATUS;
                1: a = A_TVEC;
                2: a = A_EPC;
                default: a = A_CAUSE;
            endcase
            case (op)
                0: core_wr(a, $urandom, a);
                1: do_trap($urandom, $urandom, 1'($urandom_range(0, 1)), a, $urandom,
                           1'($urandom_range(0, 1)), 1'b0);
                2: do_mret();
                3: begin
                    s0 = nstrobe;
                    do_trap($urandom, $urandom, 1'b0, a, 32'h0, 1'b0, 1'b1);
                    mret_body();
                    chk("rand_both_strobes", 32'(nstrobe - s0), 32'd2);
                end
                default: do_trap_reset($urandom, $urandom);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Controller that owns the single read port and single write port of the machine-mode CSR file (mstatus, mtvec, mepc, mcause).
- Sequences the multi-write trap-entry (ecall/exception) and mret operations over those ports.
- In IDLE, passes the core's Zicsr instruction accesses straight through; while sequencing, stalls the core.
- Ends each sequence with a one-cycle PC redirect to the fetch stage.

Parameters:
- CSR_AW, 12, CSR address width
- MSTATUS_A, 12'h300, mstatus address
- MTVEC_A, 12'h305, mtvec address
- MEPC_A, 12'h341, mepc address
- MCAUSE_A, 12'h342, mcause address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- trap_valid  in  1  trap request; held until trap_ready
- trap_ready  out  1  trap accepted this cycle
- trap_pc  in  32  faulting/ecall instruction PC
- trap_cause  in  32  mcause value
- mret_valid  in  1  mret request; held until mret_ready
- mret_ready  out  1  mret accepted this cycle
- core_csr_we  in  1  core CSR write enable (Zicsr)
- core_csr_waddr  in  CSR_AW  core write address
- core_csr_wdata  in  32  core write data
- core_csr_raddr  in  CSR_AW  core read address
- csr_out  in  32  CSR file combinational read data
- csr_write  out  1  to CSR file write enable
- csr_write_addr  out  CSR_AW  to CSR file
- csr_data  out  32  to CSR file write data
- csr_read_addr  out  CSR_AW  to CSR file read address
- busy  out  1  core stall; high in every non-IDLE state
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, M_STATUS, M_EPC, M_JUMP.
- IDLE:
  - csr_write/csr_write_addr/csr_data/csr_read_addr mirror the core_csr_* inputs combinationally; busy=0.
  - trap_valid=1: trap_ready=1, latch trap_pc->epc_q and trap_cause->cause_q, next state T_EPC.
  - Else mret_valid=1: mret_ready=1, next state M_STATUS.
  - Trap has priority over mret. A losing mret stays pending; it is accepted in the IDLE cycle after the trap completes.
  - A core write in the accept cycle is performed, so the sequence sees the updated CSR value.
- Non-IDLE states: core_csr_* ignored; csr_write=0 unless a write is listed below.
- T_EPC: write MEPC_A <- epc_q; read MSTATUS_A, capture status_q.
- T_CAUSE: write MCAUSE_A <- cause_q; read MTVEC_A, capture tvec_q.
- T_STATUS: write MSTATUS_A <- status_q with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=2'b11; all other bits unchanged.
- T_JUMP:
  - redirect_valid=1, redirect_pc={tvec_q[31:2],2'b00}. Direct mode only; mode bits are masked.
  - Next state IDLE. Trap latency from accept to redirect is 4 cycles.
- M_STATUS: read MSTATUS_A, capture status_q; no write.
- M_EPC:
  - Write MSTATUS_A <- status_q with MIE[3]=old MPIE[7], MPIE[7]=1, MPP=2'b11.
  - Read MEPC_A, capture epc_q.
- M_JUMP: redirect_valid=1, redirect_pc=epc_q; next state IDLE. Mret latency is 3 cycles.
- trap_ready/mret_ready are only ever high in IDLE and are mutually exclusive.
- redirect_valid is high for exactly one cycle per accepted request.
- redirect_pc is registered and holds its last value between strobes.
- Reset (including mid-sequence) forces IDLE next cycle:
  - busy=0, redirect_valid=0, redirect_pc=0, trap_ready=mret_ready=0.
  - Internal epc_q/cause_q/status_q/tvec_q cleared to 0.
  - No CSR write is issued in the reset cycle; any partially completed sequence is abandoned without redirect.
  - csr_write is forced to 0 while rst=1, including IDLE pass-through.

Test Plan:
- Core writes MTVEC_A=32'h8000_0100 in IDLE, then trap_valid with trap_pc=32'h8000_0040, cause=11 -> 4-cycle busy; writes in order mepc=32'h8000_0040, mcause=11, mstatus; redirect_pc=32'h8000_0100 at cycle 4.
- mstatus=32'h0000_0008 (MIE=1), trap -> written mstatus=32'h0000_1880; then mret -> written mstatus=32'h0000_1888, redirect_pc=32'h8000_0040 after 3 cycles.
- trap_valid and mret_valid asserted together and held -> trap redirect first, then mret accepted in the following IDLE cycle; exactly two redirect strobes.
- MTVEC_A written as 32'h8000_0103 -> trap redirect_pc=32'h8000_0100.
- Core write with core_csr_we=1 during T_CAUSE -> not forwarded (csr_write_addr=MCAUSE_A, csr_data=cause_q); busy=1.
- rst asserted in T_CAUSE -> next cycle IDLE, busy=0, no redirect strobe, mstatus unchanged by the sequence.
